// File: rtl/cpu_control_fsm.sv
// Moore control sequencer for the RISC CPU: fetch, PC update, decode, execute (MOV/ALU/LDR/STR/HALT).
// Outputs come from registered state only; IF1 and MEM_RD each stall MEM_LAT cycles, with no other backpressure.
module cpu_control_fsm #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       loadpc,
  output logic       loadir,
  output logic       load_addr,
  output logic       msel,
  output logic       mwrite,
  output logic       halted,
  output logic       illegal
);

  localparam logic [4:0] S_RST    = 5'd0;
  localparam logic [4:0] S_IF1    = 5'd1;
  localparam logic [4:0] S_IF2    = 5'd2;
  localparam logic [4:0] S_UPD_PC = 5'd3;
  localparam logic [4:0] S_DEC    = 5'd4;
  localparam logic [4:0] S_WR_IMM = 5'd5;
  localparam logic [4:0] S_GET_A  = 5'd6;
  localparam logic [4:0] S_GET_B  = 5'd7;
  localparam logic [4:0] S_GET_BD = 5'd8;
  localparam logic [4:0] S_ALU    = 5'd9;
  localparam logic [4:0] S_CMP_S  = 5'd10;
  localparam logic [4:0] S_WR_C   = 5'd11;
  localparam logic [4:0] S_ADDR   = 5'd12;
  localparam logic [4:0] S_LATCH  = 5'd13;
  localparam logic [4:0] S_MEM_RD = 5'd14;
  localparam logic [4:0] S_LD_WR  = 5'd15;
  localparam logic [4:0] S_PASS   = 5'd16;
  localparam logic [4:0] S_MEM_WR = 5'd17;
  localparam logic [4:0] S_HALT   = 5'd18;

  // Instruction class latched in DEC; steers the shared execute states.
  localparam logic [2:0] K_ALU = 3'd0;  // ADD / AND
  localparam logic [2:0] K_CMP = 3'd1;
  localparam logic [2:0] K_ZA  = 3'd2;  // MOV shift / MVN: A operand forced to zero
  localparam logic [2:0] K_LDR = 3'd3;
  localparam logic [2:0] K_STR = 3'd4;

  localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);

  logic [4:0] state, state_nxt;
  logic [2:0] kind, dec_kind;
  logic [1:0] cnt;
  logic       dec_ok;
  logic       illegal_q;

  always_comb begin
    dec_kind = K_ALU;
    dec_ok   = 1'b1;
    case ({opcode, op})
      5'b110_10: dec_kind = K_ALU;
      5'b110_00: dec_kind = K_ZA;
      5'b101_00: dec_kind = K_ALU;
      5'b101_01: dec_kind = K_CMP;
      5'b101_10: dec_kind = K_ALU;
      5'b101_11: dec_kind = K_ZA;
      5'b011_00: dec_kind = K_LDR;
      5'b100_00: dec_kind = K_STR;
      5'b111_00: dec_kind = K_ALU;
      default:   dec_ok   = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = S_RST;
    case (state)
      S_RST:    state_nxt = S_IF1;
      S_IF1:    state_nxt = (cnt == CNT_LAST) ? S_IF2 : S_IF1;
      S_IF2:    state_nxt = S_UPD_PC;
      S_UPD_PC: state_nxt = S_DEC;
      S_DEC: begin
        case ({opcode, op})
          5'b110_10:                       state_nxt = S_WR_IMM;
          5'b110_00, 5'b101_11:            state_nxt = S_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10,
          5'b011_00, 5'b100_00:            state_nxt = S_GET_A;
          default:                         state_nxt = S_HALT;
        endcase
      end
      S_WR_IMM: state_nxt = S_IF1;
      S_GET_A:  state_nxt = (kind == K_LDR || kind == K_STR) ? S_ADDR : S_GET_B;
      S_GET_B:  state_nxt = (kind == K_CMP) ? S_CMP_S : S_ALU;
      S_ALU:    state_nxt = S_WR_C;
      S_CMP_S:  state_nxt = S_IF1;
      S_WR_C:   state_nxt = S_IF1;
      S_ADDR:   state_nxt = S_LATCH;
      S_LATCH:  state_nxt = (kind == K_LDR) ? S_MEM_RD : S_GET_BD;
      S_MEM_RD: state_nxt = (cnt == CNT_LAST) ? S_LD_WR : S_MEM_RD;
      S_LD_WR:  state_nxt = S_IF1;
      S_GET_BD: state_nxt = S_PASS;
      S_PASS:   state_nxt = S_MEM_WR;
      S_MEM_WR: state_nxt = S_IF1;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RST;
      cnt       <= 2'd0;
      kind      <= K_ALU;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Counter runs only while a wait state holds itself, so every entry starts at zero.
      if ((state == S_IF1 || state == S_MEM_RD) && state_nxt == state)
        cnt <= cnt + 2'd1;
      else
        cnt <= 2'd0;
      if (state == S_DEC) begin
        kind <= dec_kind;
        if (!dec_ok)
          illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nsel      = 2'b00;
    vsel      = 2'b00;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    loadpc    = 1'b0;
    loadir    = 1'b0;
    load_addr = 1'b0;
    msel      = 1'b0;
    mwrite    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IF1:    msel = 1'b1;
      S_IF2:    begin msel = 1'b1; loadir = 1'b1; end
      S_UPD_PC: loadpc = 1'b1;
      S_WR_IMM: begin nsel = 2'b00; vsel = 2'b01; write = 1'b1; end
      S_GET_A:  begin nsel = 2'b00; loada = 1'b1; end
      S_GET_B:  begin nsel = 2'b10; loadb = 1'b1; end
      S_GET_BD: begin nsel = 2'b01; loadb = 1'b1; end
      S_ALU:    begin loadc = 1'b1; asel = (kind == K_ZA); end
      S_CMP_S:  loads = 1'b1;
      S_WR_C:   begin nsel = 2'b01; vsel = 2'b11; write = 1'b1; end
      S_ADDR:   begin bsel = 1'b1; loadc = 1'b1; end
      S_LATCH:  load_addr = 1'b1;
      S_MEM_RD: msel = 1'b1;
      S_LD_WR:  begin msel = 1'b1; nsel = 2'b01; vsel = 2'b00; write = 1'b1; end
      S_PASS:   begin asel = 1'b1; loadc = 1'b1; end
      S_MEM_WR: begin msel = 1'b1; mwrite = 1'b1; end
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end

  assign illegal = illegal_q;

endmodule
